// File: rtl/led_pkg.sv
// Shared constants for the LED PWM output stage: config word layout,
// LED word width and the power-on duty value.
package led_pkg;

    localparam int CFG_BLINK_BIT = 8;
    localparam int DUTY_LSB      = 0;
    localparam int LED_WIDTH     = 16;
    localparam int MAX_PWM_BITS  = 8;

    // Full brightness; the top slices off the low PWM_BITS bits.
    localparam logic [MAX_PWM_BITS-1:0] DUTY_RESET = '1;

endpackage

// File: rtl/led_pwm_timebase.sv
// PWM timebase: prescaler, PWM period counter and the period boundary pulse.
// The boundary is high for the single clock whose edge ends the period.
module led_pwm_timebase
    import led_pkg::*;
#(
    parameter int PRESCALE = 4,
    parameter int PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    output logic [PWM_BITS-1:0] pwm_cnt_o,
    output logic                boundary_o
);

    localparam int                 PRESC_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(PRESCALE - 1);

    logic [PRESC_W-1:0]  presc_q,  presc_d;
    logic [PWM_BITS-1:0] pwmCnt_q, pwmCnt_d;
    logic                tick;

    // Prescaler wraps at PRESCALE-1; the PWM counter steps once per wrap.
    always_comb begin
        tick       = (presc_q == PRESC_MAX);
        presc_d    = tick ? '0 : presc_q + 1'b1;
        pwmCnt_d   = tick ? pwmCnt_q + 1'b1 : pwmCnt_q;
        boundary_o = tick && (pwmCnt_q == '1);
        pwm_cnt_o  = pwmCnt_q;
    end

    // Counter registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            presc_q  <= '0;
            pwmCnt_q <= '0;
        end else begin
            presc_q  <= presc_d;
            pwmCnt_q <= pwmCnt_d;
        end
    end

endmodule

// File: rtl/led_pwm_driver.sv
// LED pin driver: PWM brightness and optional blinking on the latched LED word.
// Data and config are shadowed at period boundaries so a period never mixes
// two settings.
module led_pwm_driver
    import led_pkg::*;
#(
    parameter int PRESCALE      = 4,
    parameter int PWM_BITS      = 8,
    parameter int BLINK_PERIODS = 64
) (
    input  logic                 led_clk,
    input  logic                 ledrst,
    input  logic [LED_WIDTH-1:0] leddata,
    input  logic                 cfgcs,
    input  logic [15:0]          cfgwdata,
    output logic [LED_WIDTH-1:0] led_pins,
    output logic                 period_start
);

    localparam int                 BLINK_W   = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_PERIODS - 1);
    localparam logic [PWM_BITS-1:0] DUTY_INIT = DUTY_RESET[PWM_BITS-1:0];

    logic [PWM_BITS-1:0]  pwmCnt;
    logic                 boundary;

    logic [PWM_BITS-1:0]  dutyReg_q,    dutyReg_d;
    logic                 blinkEnReg_q, blinkEnReg_d;
    logic [LED_WIDTH-1:0] dataSh_q,     dataSh_d;
    logic [PWM_BITS-1:0]  dutySh_q,     dutySh_d;
    logic                 blinkSh_q,    blinkSh_d;
    logic [BLINK_W-1:0]   blinkCnt_q,   blinkCnt_d;
    logic                 blinkPhase_q, blinkPhase_d;
    logic [LED_WIDTH-1:0] ledPins_q,    ledPins_d;
    logic                 periodStart_q, periodStart_d;
    logic                 pwmOn;
    logic                 blank;
    logic                 unusedCfgBits;

    led_pwm_timebase #(
        .PRESCALE (PRESCALE),
        .PWM_BITS (PWM_BITS)
    ) u_timebase (
        .clk_i      (led_clk),
        .rst_ni     (ledrst),
        .pwm_cnt_o  (pwmCnt),
        .boundary_o (boundary)
    );

    // Only the duty field and blink enable of the config word are meaningful.
    assign unusedCfgBits = ^cfgwdata;

    // Config capture, boundary shadowing, blink phase and pin drive.
    always_comb begin
        dutyReg_d     = dutyReg_q;
        blinkEnReg_d  = blinkEnReg_q;
        dataSh_d      = dataSh_q;
        dutySh_d      = dutySh_q;
        blinkSh_d     = blinkSh_q;
        blinkCnt_d    = blinkCnt_q;
        blinkPhase_d  = blinkPhase_q;

        if (cfgcs) begin
            dutyReg_d    = cfgwdata[DUTY_LSB +: PWM_BITS];
            blinkEnReg_d = cfgwdata[CFG_BLINK_BIT];
        end

        if (boundary) begin
            dataSh_d  = leddata;
            dutySh_d  = dutyReg_q;
            blinkSh_d = blinkEnReg_q;
        end

        if (!blinkSh_q) begin
            blinkCnt_d   = '0;
            blinkPhase_d = 1'b0;
        end else if (boundary) begin
            if (blinkCnt_q == BLINK_MAX) begin
                blinkCnt_d   = '0;
                blinkPhase_d = !blinkPhase_q;
            end else begin
                blinkCnt_d   = blinkCnt_q + 1'b1;
            end
        end

        pwmOn         = (dutySh_q == '1) || (pwmCnt < dutySh_q);
        blank         = blinkSh_q && blinkPhase_q;
        ledPins_d     = dataSh_q & {LED_WIDTH{pwmOn && !blank}};
        periodStart_d = boundary;
    end

    // State registers; reset comes back at full brightness with blinking off.
    always_ff @(posedge led_clk or negedge ledrst) begin
        if (!ledrst) begin
            dutyReg_q     <= DUTY_INIT;
            blinkEnReg_q  <= 1'b0;
            dataSh_q      <= '0;
            dutySh_q      <= DUTY_INIT;
            blinkSh_q     <= 1'b0;
            blinkCnt_q    <= '0;
            blinkPhase_q  <= 1'b0;
            ledPins_q     <= '0;
            periodStart_q <= 1'b0;
        end else begin
            dutyReg_q     <= dutyReg_d;
            blinkEnReg_q  <= blinkEnReg_d;
            dataSh_q      <= dataSh_d;
            dutySh_q      <= dutySh_d;
            blinkSh_q     <= blinkSh_d;
            blinkCnt_q    <= blinkCnt_d;
            blinkPhase_q  <= blinkPhase_d;
            ledPins_q     <= ledPins_d;
            periodStart_q <= periodStart_d;
        end
    end

    assign led_pins     = ledPins_q;
    assign period_start = periodStart_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Directed bench for led_pwm_driver with PRESCALE=2, PWM_BITS=4,
// BLINK_PERIODS=2 (32-cycle PWM period). "cyc" is the index of the last
// rising edge after reset release; outputs are sampled 1 ns after it.
module tb_led_pwm_driver;

    logic        led_clk;
    logic        ledrst;
    logic [15:0] leddata;
    logic        cfgcs;
    logic [15:0] cfgwdata;
    logic [15:0] led_pins;
    logic        period_start;

    int assertCount = 0;
    int failCount   = 0;
    int cyc         = -1;

    led_pwm_driver #(
        .PRESCALE      (2),
        .PWM_BITS      (4),
        .BLINK_PERIODS (2)
    ) dut (
        .led_clk      (led_clk),
        .ledrst       (ledrst),
        .leddata      (leddata),
        .cfgcs        (cfgcs),
        .cfgwdata     (cfgwdata),
        .led_pins     (led_pins),
        .period_start (period_start)
    );

    initial led_clk = 1'b0;
    always #5 led_clk = ~led_clk;

    // Expected pins for a period showing data d at duty, position pos in the period.
    function automatic logic [15:0] expPins(input logic [15:0] d, input int duty, input int pos);
        if (duty == 15)        return d;
        else if (pos / 2 < duty) return d;
        else                   return 16'h0000;
    endfunction

    task automatic stepEdge();
        @(posedge led_clk);
        #1;
        cyc++;
        cfgcs = 1'b0;
    endtask

    task automatic applyStimulus(input logic cs, input logic [15:0] wdata);
        cfgcs    = cs;
        cfgwdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] pinsExp, input logic psExp);
        assertCount++;
        assert (led_pins === pinsExp) else begin
            failCount++;
            $error("[TB] FAIL %s led_pins cyc=%0d: observed %h expected %h", tag, cyc, led_pins, pinsExp);
        end
        assertCount++;
        assert (period_start === psExp) else begin
            failCount++;
            $error("[TB] FAIL %s period_start cyc=%0d: observed %b expected %b", tag, cyc, period_start, psExp);
        end
    endtask

    initial begin
        logic [15:0] e;
        ledrst   = 1'b0;
        leddata  = 16'hA5A5;
        cfgcs    = 1'b0;
        cfgwdata = 16'h0000;

        // Held in reset across a few edges.
        repeat (3) @(posedge led_clk);
        #1;
        checkOutput("reset", 16'h0000, 1'b0);
        @(negedge led_clk);
        ledrst = 1'b1;
        cyc    = -1;

        // Power-on: dark for the first period, then full-brightness A5A5.
        repeat (96) begin
            stepEdge();
            checkOutput("powerup", (cyc < 32) ? 16'h0000 : 16'hA5A5, (cyc % 32) == 31);
        end

        // Duty 4 written mid-window 3, applies from window 4 (cycle 128).
        applyStimulus(1'b1, 16'h0004);
        repeat (96) begin
            stepEdge();
            e = (cyc < 128) ? 16'hA5A5 : expPins(16'hA5A5, 4, cyc % 32);
            checkOutput("duty4", e, (cyc % 32) == 31);
        end

        // Duty 0 applies from cycle 224.
        applyStimulus(1'b1, 16'h0000);
        repeat (64) begin
            stepEdge();
            e = (cyc < 224) ? expPins(16'hA5A5, 4, cyc % 32) : 16'h0000;
            checkOutput("duty0", e, (cyc % 32) == 31);
        end

        // Duty 15 applies from cycle 288.
        applyStimulus(1'b1, 16'h000F);
        repeat (64) begin
            stepEdge();
            e = (cyc < 288) ? 16'h0000 : 16'hA5A5;
            checkOutput("dutyF", e, (cyc % 32) == 31);
        end

        // Blink on from cycle 352: 64 on, then blank from 416; disable at 420 unblanks from 448.
        applyStimulus(1'b1, 16'h010F);
        repeat (224) begin
            stepEdge();
            e = (cyc >= 416 && cyc < 448) ? 16'h0000 : 16'hA5A5;
            checkOutput("blink", e, (cyc % 32) == 31);
            if (cyc == 419) applyStimulus(1'b1, 16'h000F);
        end

        // Data 00FF at duty 8 from 576; FF00 changed mid-period shows from 608;
        // duty 2 written on the boundary cycle 639 applies from 672.
        leddata = 16'h00FF;
        applyStimulus(1'b1, 16'h0008);
        repeat (162) begin
            stepEdge();
            if (cyc < 576)      e = 16'hA5A5;
            else if (cyc < 608) e = expPins(16'h00FF, 8, cyc % 32);
            else if (cyc < 672) e = expPins(16'hFF00, 8, cyc % 32);
            else                e = expPins(16'hFF00, 2, cyc % 32);
            checkOutput("datachg", e, (cyc % 32) == 31);
            if (cyc == 585) leddata = 16'hFF00;
            if (cyc == 638) applyStimulus(1'b1, 16'h0002);
        end

        // Asynchronous reset between edges while pins are lit.
        #2;
        ledrst = 1'b0;
        #1;
        checkOutput("asyncrst", 16'h0000, 1'b0);
        repeat (2) @(posedge led_clk);
        #1;
        checkOutput("rsthold", 16'h0000, 1'b0);
        @(negedge led_clk);
        ledrst = 1'b1;
        cyc    = -1;

        // After reset: data cleared until the first boundary, duty back to full.
        repeat (64) begin
            stepEdge();
            checkOutput("afterrst", (cyc < 32) ? 16'h0000 : 16'hFF00, (cyc % 32) == 31);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
